// File: rtl/mac_pkg.sv
// Shared MAC-datapath definitions: divider FSM encoding, default widths
// common with the Wallace-tree multiplier, and the divide-by-zero quotient.
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Product width / operand width of the low-precision multiplier.
  localparam int unsigned MAC_DW = 8;
  localparam int unsigned MAC_VW = 2;

  // Quotient reported for a zero divisor: all ones, sliced to the user width.
  localparam logic [63:0] DBZ_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-
// subtract the divisor, keep the difference when it does not go negative.
module div_step #(
  parameter int VW = 2
) (
  input  logic [VW:0]   r_i,
  input  logic          bit_i,
  input  logic [VW-1:0] d_i,
  output logic [VW:0]   r_o,
  output logic          q_o
);

  logic [VW:0] t;

  // Trial subtraction. r_i stays below the divisor, so its top bit is normally
  // zero; if it were set, 2R+b would exceed any divisor, so it forces a 1.
  always_comb begin
    t   = {r_i[VW-1:0], bit_i};
    q_o = r_i[VW] | (t >= {1'b0, d_i});
    r_o = q_o ? (t - {1'b0, d_i}) : t;
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock, with
// valid/ready handshakes on both sides. No overlap between operations.
module seq_divider
  import mac_pkg::*;
#(
  parameter int DW = MAC_DW,
  parameter int VW = MAC_VW,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  div_state_e    st_q, st_d;
  logic          rdy_en_q;   // keeps in_ready low until the first edge after reset
  logic [DW-1:0] q_q;        // dividend in, quotient bits shift in from the right
  logic [VW-1:0] d_q;
  logic [VW:0]   r_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] quot_q;
  logic [VW-1:0] rem_q;
  logic          dbz_q;

  logic [VW:0]   r_nxt;
  logic          qbit;
  logic          accept;

  div_step #(.VW(VW)) u_step (
    .r_i   (r_q),
    .bit_i (q_q[DW-1]),
    .d_i   (d_q),
    .r_o   (r_nxt),
    .q_o   (qbit)
  );

  assign accept      = in_valid && in_ready;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= ST_IDLE;
    else        st_q <= st_d;
  end

  // Next-state logic.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE: if (accept)          st_d = (divisor == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (cnt_q == '0)     st_d = ST_DONE;
      ST_DONE: if (out_ready)       st_d = ST_IDLE;
      default:                      st_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = rdy_en_q && (st_q == ST_IDLE);
    out_valid = (st_q == ST_DONE);
  end

  // Datapath: operand capture, shift/subtract iterations, result registers.
  // Result registers only load on entry to DONE so they hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
      q_q      <= '0;
      d_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      unique case (st_q)
        ST_IDLE: begin
          if (accept) begin
            q_q   <= dividend;
            d_q   <= divisor;
            r_q   <= '0;
            cnt_q <= CW'(DW - 1);
            if (divisor == '0) begin
              quot_q <= DBZ_QUOT[DW-1:0];
              rem_q  <= '0;
              dbz_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          q_q <= {q_q[DW-2:0], qbit};
          r_q <= r_nxt;
          if (cnt_q == '0) begin
            quot_q <= {q_q[DW-2:0], qbit};
            rem_q  <= r_nxt[VW-1:0];
            dbz_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed + scoreboarded random bench for seq_divider (DW=8, VW=2).
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] dividend;
  logic [1:0] divisor;
  logic       out_valid, out_ready;
  logic [7:0] quotient;
  logic [1:0] remainder;
  logic       div_by_zero;

  int checks   = 0;
  int failures = 0;

  seq_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dvd;
    logic [1:0] dvs;
    logic [7:0] q;
    logic [1:0] r;
    logic       dbz;
    int         lat;   // edges from the accept edge (inclusive) to out_valid
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_in_ready"},  int'(in_ready),    0);
    chk({nm, "_out_valid"}, int'(out_valid),   0);
    chk({nm, "_quot"},      int'(quotient),    0);
    chk({nm, "_rem"},       int'(remainder),   0);
    chk({nm, "_dbz"},       int'(div_by_zero), 0);
  endtask

  // Bounded wait (at negedges) for in_ready.
  task automatic wait_ready(input string nm);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk({nm, "_ready_timeout"}, 0, 1);
  endtask

  // Present one operand pair at a negedge, count edges until out_valid.
  task automatic issue(input logic [7:0] a, input logic [1:0] b, output int lat);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_valid = 1'b0;
    end while (!out_valid && lat < 40);
  endtask

  // Accept the result and check that the block is free again next cycle.
  task automatic retire(input string nm);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_ovalid_drop"}, int'(out_valid), 0);
    chk({nm, "_iready_back"}, int'(in_ready),  1);
  endtask

  logic [7:0] dq[$];
  logic [1:0] vq[$];

  initial begin
    int lat, bad, nres, nacc, cyc;
    logic [7:0] ea, eq;
    logic [1:0] eb, er;
    logic       ez;

    vecs[0] = '{8'd200, 2'd3, 8'd66,  2'd2, 1'b0, 9};
    vecs[1] = '{8'd255, 2'd1, 8'd255, 2'd0, 1'b0, 9};
    vecs[2] = '{8'd0,   2'd2, 8'd0,   2'd0, 1'b0, 9};
    vecs[3] = '{8'd5,   2'd3, 8'd1,   2'd2, 1'b0, 9};
    vecs[4] = '{8'd7,   2'd0, 8'hFF,  2'd0, 1'b1, 1};
    vecs[5] = '{8'd255, 2'd3, 8'd85,  2'd0, 1'b0, 9};
    vecs[6] = '{8'd13,  2'd2, 8'd6,   2'd1, 1'b0, 9};
    vecs[7] = '{8'd1,   2'd3, 8'd0,   2'd1, 1'b0, 9};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk_reset_outs("por");
    rst_n = 1'b1;
    #1 chk("por_ready_before_edge", int'(in_ready), 0);
    @(negedge clk);
    chk("por_ready_after_edge", int'(in_ready), 1);

    // Table-driven vectors
    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d_%0d_%0d", i, vecs[i].dvd, vecs[i].dvs);
      wait_ready(nm);
      issue(vecs[i].dvd, vecs[i].dvs, lat);
      chk({nm, "_lat"},  lat, vecs[i].lat);
      chk({nm, "_ovalid"}, int'(out_valid), 1);
      chk({nm, "_iready_busy"}, int'(in_ready), 0);
      chk({nm, "_quot"}, int'(quotient),    int'(vecs[i].q));
      chk({nm, "_rem"},  int'(remainder),   int'(vecs[i].r));
      chk({nm, "_dbz"},  int'(div_by_zero), int'(vecs[i].dbz));
      retire(nm);
    end

    // Backpressure on 100/3, with a competing in_valid that must be ignored
    wait_ready("bp");
    issue(8'd100, 2'd3, lat);
    chk("bp_lat", lat, 9);
    in_valid = 1'b1; dividend = 8'd9; divisor = 2'd2;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (!out_valid || in_ready || quotient != 8'd33 || remainder != 2'd1 || div_by_zero)
        bad++;
      @(negedge clk);
    end
    chk("bp_hold_cycles_bad", bad, 0);
    in_valid = 1'b0;
    chk("bp_quot", int'(quotient), 33);
    chk("bp_rem",  int'(remainder), 1);
    retire("bp");
    @(negedge clk);
    chk("bp_no_stray_result", int'(out_valid), 0);

    // Reset mid-RUN of 200/3
    wait_ready("rst");
    in_valid = 1'b1; dividend = 8'd200; divisor = 2'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset_outs("rst_async");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_reset_outs($sformatf("rst_hold%0d", c));
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_after_release", int'(in_ready), 1);
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      if (out_valid) bad++;
      @(negedge clk);
    end
    chk("rst_aborted_result_seen", bad, 0);

    // Random traffic with scoreboard
    nres = 0; nacc = 0; cyc = 0;
    while (nres < 400 && cyc < 20000) begin
      in_valid  = (nacc < 400) && ($urandom_range(0, 1) == 1);
      dividend  = 8'($urandom);
      divisor   = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        dq.push_back(dividend);
        vq.push_back(divisor);
        nacc++;
      end
      if (out_valid && out_ready) begin
        nres++;
        if (dq.size() == 0) begin
          chk("rnd_unexpected_result", 1, 0);
        end else begin
          ea = dq.pop_front();
          eb = vq.pop_front();
          if (eb == 2'd0) begin
            eq = 8'hFF; er = 2'd0; ez = 1'b1;
          end else begin
            eq = ea / {6'd0, eb}; er = 2'(ea % {6'd0, eb}); ez = 1'b0;
            chk("rnd_invariant", int'(quotient) * int'(divisor == divisor ? eb : eb) + int'(remainder), int'(ea));
            chk("rnd_rem_lt_div", int'(remainder < eb), 1);
          end
          chk($sformatf("rnd_quot_%0d_%0d", ea, eb), int'(quotient),    int'(eq));
          chk($sformatf("rnd_rem_%0d_%0d",  ea, eb), int'(remainder),   int'(er));
          chk($sformatf("rnd_dbz_%0d_%0d",  ea, eb), int'(div_by_zero), int'(ez));
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rnd_results", nres, 400);
    chk("rnd_accepted", nacc, 400);
    chk("rnd_leftover", dq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
